// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared op codes, result classes and divider state encoding
package ex_stage_pkg;

    localparam logic [7:0] ALU_OP_NOP   = 8'h00;
    localparam logic [7:0] ALU_OP_OR    = 8'h01;
    localparam logic [7:0] ALU_OP_AND   = 8'h02;
    localparam logic [7:0] ALU_OP_XOR   = 8'h03;
    localparam logic [7:0] ALU_OP_NOR   = 8'h04;
    localparam logic [7:0] ALU_OP_ADD   = 8'h10;
    localparam logic [7:0] ALU_OP_ADDU  = 8'h11;
    localparam logic [7:0] ALU_OP_SUB   = 8'h12;
    localparam logic [7:0] ALU_OP_SUBU  = 8'h13;
    localparam logic [7:0] ALU_OP_SLT   = 8'h14;
    localparam logic [7:0] ALU_OP_SLTU  = 8'h15;
    localparam logic [7:0] ALU_OP_SLL   = 8'h20;
    localparam logic [7:0] ALU_OP_SRL   = 8'h21;
    localparam logic [7:0] ALU_OP_SRA   = 8'h22;
    localparam logic [7:0] ALU_OP_MULT  = 8'h30;
    localparam logic [7:0] ALU_OP_MULTU = 8'h31;
    localparam logic [7:0] ALU_OP_DIV   = 8'h32;
    localparam logic [7:0] ALU_OP_DIVU  = 8'h33;
    localparam logic [7:0] ALU_OP_MFHI  = 8'h34;
    localparam logic [7:0] ALU_OP_MFLO  = 8'h35;
    localparam logic [7:0] ALU_OP_MTHI  = 8'h36;
    localparam logic [7:0] ALU_OP_MTLO  = 8'h37;

    typedef enum logic [2:0] {
        ALU_RES_NOP   = 3'd0,
        ALU_RES_LOGIC = 3'd1,
        ALU_RES_SHIFT = 3'd2,
        ALU_RES_ARITH = 3'd3,
        ALU_RES_MOVE  = 3'd4,
        ALU_RES_JUMP  = 3'd5
    } alu_res_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - id/ex operation bundle in, write-back bundle out
interface ex_stage_if;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] return_addr_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        ov_o;
    logic        stallreq_o;

    modport master (
        output flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, return_addr_i,
        input  wd_o, wreg_o, wdata_o, ov_o, stallreq_o
    );

    modport slave (
        input  flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, return_addr_i,
        output wd_o, wreg_o, wdata_o, ov_o, stallreq_o
    );
endinterface

// File: rtl/ex_stage_div_unit.sv
// rtl/ex_stage_div_unit.sv - restoring divider on magnitudes, one step per cycle
module ex_stage_div_unit
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CNT_W = $clog2(DIV_ITER + 1);

    div_state_e state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0] quo, rem, dvs;
    logic        neg_q, neg_r;
    logic [31:0] mag_a, mag_b;
    logic [32:0] partial;
    logic [33:0] trial;
    logic        last_step;

    assign mag_a     = (signed_op && dividend[31]) ? -dividend : dividend;
    assign mag_b     = (signed_op && divisor[31])  ? -divisor  : divisor;
    assign partial   = {rem, quo[31]};
    assign trial     = {1'b0, partial} - {2'b00, dvs};
    assign last_step = (cnt == CNT_W'(DIV_ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DIV_IDLE && start && !flush) begin
                quo   <= mag_a;
                rem   <= '0;
                dvs   <= mag_b;
                neg_q <= signed_op & (dividend[31] ^ divisor[31]);
                neg_r <= signed_op & dividend[31];
                cnt   <= '0;
            end else if (state == DIV_BUSY) begin
                // trial[33] set means the subtraction would go negative: restore
                quo <= {quo[30:0], ~trial[33]};
                rem <= trial[33] ? partial[31:0] : trial[31:0];
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (start) state_next = DIV_BUSY;
                DIV_BUSY: if (last_step) state_next = DIV_DONE;
                DIV_DONE: state_next = DIV_IDLE;
                default:  state_next = DIV_IDLE;
            endcase
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE) && !flush;
    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;
endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, HI/LO, multiplier and divider stall
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    logic [31:0] hi, lo;
    logic [31:0] a, b, sum, diff, result;
    logic [63:0] prod;
    logic [7:0]  op;
    logic        is_mult, is_div, hilo_op, ov;
    logic        div_start, div_busy, div_done;
    logic [31:0] div_q, div_r;

    assign op   = bus.aluop_i;
    assign a    = bus.reg1_i;
    assign b    = bus.reg2_i;
    assign sum  = a + b;
    assign diff = a - b;

    // Sign-extending for MULT makes the low 64 bits of the product the signed result
    assign prod = {{32{(op == ALU_OP_MULT) & a[31]}}, a} * {{32{(op == ALU_OP_MULT) & b[31]}}, b};

    assign is_mult   = (op == ALU_OP_MULT) || (op == ALU_OP_MULTU);
    assign is_div    = (op == ALU_OP_DIV)  || (op == ALU_OP_DIVU);
    assign hilo_op   = is_mult || is_div || (op == ALU_OP_MTHI) || (op == ALU_OP_MTLO);
    assign div_start = is_div && (b != 32'd0);

    assign ov = ((op == ALU_OP_ADD) && (a[31] == b[31]) && (sum[31] != a[31])) ||
                ((op == ALU_OP_SUB) && (a[31] != b[31]) && (diff[31] != a[31]));

    ex_stage_div_unit #(.DIV_ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (op == ALU_OP_DIV),
        .dividend  (a),
        .divisor   (b),
        .flush     (bus.flush_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        result = 32'd0;
        case (alu_res_e'(bus.alusel_i))
            ALU_RES_LOGIC: case (op)
                ALU_OP_OR:  result = a | b;
                ALU_OP_AND: result = a & b;
                ALU_OP_XOR: result = a ^ b;
                ALU_OP_NOR: result = ~(a | b);
                default:    result = 32'd0;
            endcase
            ALU_RES_SHIFT: case (op)
                ALU_OP_SLL: result = b << a[4:0];
                ALU_OP_SRL: result = b >> a[4:0];
                ALU_OP_SRA: result = $unsigned($signed(b) >>> a[4:0]);
                default:    result = 32'd0;
            endcase
            ALU_RES_ARITH: case (op)
                ALU_OP_ADD, ALU_OP_ADDU: result = sum;
                ALU_OP_SUB, ALU_OP_SUBU: result = diff;
                ALU_OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
                ALU_OP_SLTU: result = {31'd0, a < b};
                default:     result = 32'd0;
            endcase
            ALU_RES_MOVE: case (op)
                ALU_OP_MFHI: result = hi;
                ALU_OP_MFLO: result = lo;
                default:     result = 32'd0;
            endcase
            ALU_RES_JUMP: result = bus.return_addr_i;
            default:      result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (div_done) begin
            hi <= div_r;
            lo <= div_q;
        end else if (is_mult) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
        end else if (op == ALU_OP_MTHI) begin
            hi <= a;
        end else if (op == ALU_OP_MTLO) begin
            lo <= a;
        end
    end

    assign bus.wd_o       = bus.wd_i;
    assign bus.wreg_o     = bus.wreg_i && !ov && !hilo_op;
    assign bus.wdata_o    = result;
    assign bus.ov_o       = ov;
    assign bus.stallreq_o = div_busy || (div_start && !bus.flush_i && u_div.state == DIV_IDLE);
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - vector table plus scoreboard checks for ex_stage
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage #(.DIV_ITER(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a, b, ra;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_wreg, exp_ov;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  wd;
        logic        chk_data;
        logic [31:0] data;
        logic        wreg, ov;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic [31:0] ra);
        @(posedge clk);
        #1;
        bus.flush_i       = 1'b0;
        bus.aluop_i       = op;
        bus.alusel_i      = sel;
        bus.reg1_i        = a;
        bus.reg2_i        = b;
        bus.wd_i          = wd;
        bus.wreg_i        = 1'b1;
        bus.return_addr_i = ra;
    endtask

    task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(ALU_OP_MFHI, 3'(ALU_RES_MOVE), 32'd0, 32'd0, 5'd2, 32'd0);
        @(negedge clk);
        check({name, " mfhi"}, bus.wdata_o, exp_hi);
        drive(ALU_OP_MFLO, 3'(ALU_RES_MOVE), 32'd0, 32'd0, 5'd3, 32'd0);
        @(negedge clk);
        check({name, " mflo"}, bus.wdata_o, exp_lo);
    endtask

    // Counts consecutive stalled cycles after a divide issue; leaves the bench in the first unstalled cycle
    task automatic count_stall(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.stallreq_o) n++;
            else break;
        end
    endtask

    function automatic vec_t mk(input string name, input logic [7:0] op, input logic [2:0] sel,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] ra,
                                input logic chk, input logic [31:0] d, input logic w, input logic o);
        vec_t v;
        v.name = name; v.op = op; v.sel = sel; v.a = a; v.b = b; v.ra = ra;
        v.chk_data = chk; v.exp_data = d; v.exp_wreg = w; v.exp_ov = o;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   n;
        exp_t e;
        bus.flush_i = 1'b0; bus.aluop_i = ALU_OP_NOP; bus.alusel_i = 3'd0;
        bus.reg1_i = '0; bus.reg2_i = '0; bus.wd_i = '0; bus.wreg_i = 1'b0; bus.return_addr_i = '0;

        vecs.push_back(mk("or",    ALU_OP_OR,   3'(ALU_RES_LOGIC), 32'hF0F0_0000, 32'h0F0F_00FF, 0, 1, 32'hFFFF_00FF, 1, 0));
        vecs.push_back(mk("and",   ALU_OP_AND,  3'(ALU_RES_LOGIC), 32'hF0F0_1234, 32'hFF00_FF00, 0, 1, 32'hF000_1200, 1, 0));
        vecs.push_back(mk("xor",   ALU_OP_XOR,  3'(ALU_RES_LOGIC), 32'hAAAA_5555, 32'hFFFF_0000, 0, 1, 32'h5555_5555, 1, 0));
        vecs.push_back(mk("nor",   ALU_OP_NOR,  3'(ALU_RES_LOGIC), 32'h0000_00F0, 32'h0000_000F, 0, 1, 32'hFFFF_FF00, 1, 0));
        vecs.push_back(mk("addu",  ALU_OP_ADDU, 3'(ALU_RES_ARITH), 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 1, 0));
        vecs.push_back(mk("add_ov",ALU_OP_ADD,  3'(ALU_RES_ARITH), 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk("add",   ALU_OP_ADD,  3'(ALU_RES_ARITH), 32'h5, 32'hFFFF_FFFD, 0, 1, 32'h2, 1, 0));
        vecs.push_back(mk("sub_ov",ALU_OP_SUB,  3'(ALU_RES_ARITH), 32'h8000_0000, 32'h1, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk("subu",  ALU_OP_SUBU, 3'(ALU_RES_ARITH), 32'h0, 32'h1, 0, 1, 32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk("slt",   ALU_OP_SLT,  3'(ALU_RES_ARITH), 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h1, 1, 0));
        vecs.push_back(mk("sltu",  ALU_OP_SLTU, 3'(ALU_RES_ARITH), 32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 1, 0));
        vecs.push_back(mk("sll",   ALU_OP_SLL,  3'(ALU_RES_SHIFT), 32'h4, 32'h1, 0, 1, 32'h10, 1, 0));
        vecs.push_back(mk("srl",   ALU_OP_SRL,  3'(ALU_RES_SHIFT), 32'h4, 32'h8000_0000, 0, 1, 32'h0800_0000, 1, 0));
        vecs.push_back(mk("sra",   ALU_OP_SRA,  3'(ALU_RES_SHIFT), 32'h4, 32'h8000_0000, 0, 1, 32'hF800_0000, 1, 0));
        vecs.push_back(mk("jal",   ALU_OP_NOP,  3'(ALU_RES_JUMP),  32'h0, 32'h0, 32'h0040_1234, 1, 32'h0040_1234, 1, 0));
        vecs.push_back(mk("nop",   ALU_OP_OR,   3'(ALU_RES_NOP),   32'hFFFF_FFFF, 32'h1, 0, 1, 32'h0, 1, 0));

        // Reset with the NOP bundle: everything reads zero
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("reset wdata", bus.wdata_o, 32'd0);
        check("reset wreg", 32'(bus.wreg_o), 32'd0);
        check("reset ov", 32'(bus.ov_o), 32'd0);
        check("reset stall", 32'(bus.stallreq_o), 32'd0);
        check("reset wd", 32'(bus.wd_o), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        read_hilo("after reset", 32'd0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].ra);
            e.name = vecs[i].name; e.wd = 5'(i + 1); e.chk_data = vecs[i].chk_data;
            e.data = vecs[i].exp_data; e.wreg = vecs[i].exp_wreg; e.ov = vecs[i].exp_ov;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            if (e.chk_data) check({e.name, " wdata"}, bus.wdata_o, e.data);
            check({e.name, " wreg"}, 32'(bus.wreg_o), 32'(e.wreg));
            check({e.name, " ov"}, 32'(bus.ov_o), 32'(e.ov));
            check({e.name, " wd"}, 32'(bus.wd_o), 32'(e.wd));
        end

        drive(ALU_OP_MULT, 3'(ALU_RES_NOP), 32'hFFFF_FFFE, 32'h3, 5'd4, 32'd0);
        @(negedge clk);
        check("mult wreg", 32'(bus.wreg_o), 32'd0);
        check("mult stall", 32'(bus.stallreq_o), 32'd0);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        drive(ALU_OP_MULTU, 3'(ALU_RES_NOP), 32'hFFFF_FFFF, 32'h2, 5'd4, 32'd0);
        read_hilo("multu", 32'h1, 32'hFFFF_FFFE);
        drive(ALU_OP_MTHI, 3'(ALU_RES_NOP), 32'h1111_2222, 32'h0, 5'd4, 32'd0);
        drive(ALU_OP_MTLO, 3'(ALU_RES_NOP), 32'h3333_4444, 32'h0, 5'd4, 32'd0);
        read_hilo("mthi/mtlo", 32'h1111_2222, 32'h3333_4444);

        drive(ALU_OP_DIV, 3'(ALU_RES_NOP), 32'hFFFF_FFF9, 32'h2, 5'd5, 32'd0);
        count_stall(n);
        check("div stall cycles", 32'(n), 32'd33);
        check("div done wreg", 32'(bus.wreg_o), 32'd0);
        read_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        drive(ALU_OP_DIVU, 3'(ALU_RES_NOP), 32'd100, 32'd7, 5'd5, 32'd0);
        count_stall(n);
        check("divu stall cycles", 32'(n), 32'd33);
        drive(ALU_OP_DIVU, 3'(ALU_RES_NOP), 32'h8000_0000, 32'd3, 5'd5, 32'd0);
        count_stall(n);
        check("back-to-back divu stall cycles", 32'(n), 32'd33);
        read_hilo("divu 2^31/3", 32'h2, 32'h2AAA_AAAA);

        drive(ALU_OP_DIVU, 3'(ALU_RES_NOP), 32'd5, 32'd0, 5'd5, 32'd0);
        @(negedge clk);
        check("div0 stall", 32'(bus.stallreq_o), 32'd0);
        check("div0 wreg", 32'(bus.wreg_o), 32'd0);
        read_hilo("div0", 32'h2, 32'h2AAA_AAAA);

        drive(ALU_OP_DIV, 3'(ALU_RES_NOP), 32'd100, 32'd3, 5'd5, 32'd0);
        for (int k = 0; k < 10; k++) @(posedge clk);
        #1; bus.flush_i = 1'b1;
        drive(ALU_OP_NOP, 3'(ALU_RES_NOP), 32'd0, 32'd0, 5'd0, 32'd0);
        @(negedge clk);
        check("flush stall", 32'(bus.stallreq_o), 32'd0);
        for (int k = 0; k < 40; k++) @(posedge clk);
        read_hilo("flush", 32'h2, 32'h2AAA_AAAA);

        drive(ALU_OP_DIV, 3'(ALU_RES_NOP), 32'd1000, 32'd7, 5'd5, 32'd0);
        for (int k = 0; k < 6; k++) @(posedge clk);
        #1; rst = 1'b1;
        bus.aluop_i = ALU_OP_NOP; bus.alusel_i = 3'd0; bus.reg1_i = '0; bus.reg2_i = '0;
        bus.wd_i = '0; bus.wreg_i = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("mid-div reset stall", 32'(bus.stallreq_o), 32'd0);
        check("mid-div reset wdata", bus.wdata_o, 32'd0);
        read_hilo("mid-div reset", 32'd0, 32'd0);
        drive(ALU_OP_DIVU, 3'(ALU_RES_NOP), 32'd9, 32'd4, 5'd5, 32'd0);
        count_stall(n);
        check("post-reset divu stall cycles", 32'(n), 32'd33);
        read_hilo("divu 9/4", 32'd1, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
